// File: rtl/d_cache_pkg.sv
// Shared types and byte-lane helpers for the two-way write-back data cache.
package d_cache_pkg;

    typedef enum logic [1:0] {IDLE, WB, RF, DONE} state_e;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = mask[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/d_cache_wb_2way_way.sv
// One cache way: valid/dirty/tag per set plus a word-addressed data array.
module d_cache_way
    import d_cache_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INDEX_WIDTH-1:0]    idx,
    input  logic [OFFSET_WIDTH-3:0]   word,
    output logic                      rd_valid,
    output logic                      rd_dirty,
    output logic [TAG_WIDTH-1:0]      rd_tag,
    output logic [31:0]               rd_data,
    input  logic                      data_we,
    input  logic [3:0]                data_mask,
    input  logic [31:0]               data_wdata,
    input  logic                      dirty_set,
    input  logic                      line_we,
    input  logic [TAG_WIDTH-1:0]      line_tag,
    input  logic                      line_dirty
);
    localparam int SETS  = 2 ** INDEX_WIDTH;
    localparam int WORDS = 2 ** (OFFSET_WIDTH - 2);

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_WIDTH-1:0] tag_q [SETS];
    logic [31:0]          data_q [SETS*WORDS];
    logic [INDEX_WIDTH+OFFSET_WIDTH-3:0] daddr;

    assign daddr    = {idx, word};
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[daddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= line_dirty;
        end else if (dirty_set) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (line_we) tag_q[idx] <= line_tag;
        if (data_we) data_q[daddr] <= merge(data_q[daddr], data_wdata, data_mask);
    end

endmodule

// File: rtl/d_cache_wb_2way.sv
// Two-way set-associative write-back, write-allocate data cache between core and bridge.
module d_cache_wb_2way
    import d_cache_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WBITS     = OFFSET_WIDTH - 2;
    localparam int SETS      = 2 ** INDEX_WIDTH;
    localparam logic [WBITS-1:0] LAST = '1;

    state_e                 state_q, state_d;
    logic [WBITS-1:0]       cnt_q, cnt_d;
    logic                   addr_rcv_q, addr_rcv_d;
    logic [TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
    logic [INDEX_WIDTH-1:0] req_index_q, req_index_d;
    logic [WBITS-1:0]       req_word_q, req_word_d;
    logic                   victim_q, victim_d;
    logic                   lru_q [SETS];

    logic [TAG_WIDTH-1:0]   cpu_tag;
    logic [INDEX_WIDTH-1:0] cpu_index, acc_index;
    logic [WBITS-1:0]       cpu_word, acc_word;
    logic                   hit0, hit1, victim, lru_we, lru_val, line_dirty;
    logic [1:0]             rd_valid, rd_dirty, data_we, dirty_set, line_we;
    logic [TAG_WIDTH-1:0]   rd_tag [2];
    logic [31:0]            rd_data [2];
    logic [3:0]             data_mask;
    logic [31:0]            data_wdata;

    assign cpu_tag   = cpu_data_addr[31 -: TAG_WIDTH];
    assign cpu_index = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_word  = cpu_data_addr[2 +: WBITS];
    assign acc_index = (state_q == IDLE) ? cpu_index : req_index_q;
    assign acc_word  = (state_q == IDLE) ? cpu_word :
                       (state_q == DONE) ? req_word_q : cnt_q;
    assign hit0      = rd_valid[0] && (rd_tag[0] == cpu_tag);
    assign hit1      = rd_valid[1] && (rd_tag[1] == cpu_tag);

    for (genvar w = 0; w < 2; w++) begin : g_way
        d_cache_way #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .OFFSET_WIDTH(OFFSET_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .idx       (acc_index),
            .word      (acc_word),
            .rd_valid  (rd_valid[w]),
            .rd_dirty  (rd_dirty[w]),
            .rd_tag    (rd_tag[w]),
            .rd_data   (rd_data[w]),
            .data_we   (data_we[w]),
            .data_mask (data_mask),
            .data_wdata(data_wdata),
            .dirty_set (dirty_set[w]),
            .line_we   (line_we[w]),
            .line_tag  (req_tag_q),
            .line_dirty(line_dirty)
        );
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_rcv_d       = addr_rcv_q;
        req_tag_d        = req_tag_q;
        req_index_d      = req_index_q;
        req_word_d       = req_word_q;
        victim_d         = victim_q;
        victim           = 1'b0;
        lru_we           = 1'b0;
        lru_val          = 1'b0;
        data_we          = 2'b00;
        dirty_set        = 2'b00;
        line_we          = 2'b00;
        line_dirty       = 1'b0;
        data_mask        = byte_mask(cpu_data_size, cpu_data_addr[1:0]);
        data_wdata       = cpu_data_wdata;
        cpu_data_rdata   = '0;
        cpu_data_addr_ok = 1'b0;
        cpu_data_data_ok = 1'b0;
        cache_data_req   = 1'b0;
        cache_data_wr    = 1'b0;
        cache_data_size  = 2'b00;
        cache_data_addr  = '0;
        cache_data_wdata = '0;
        if (!rst) begin
            cache_data_size = 2'b10;
            case (state_q)
                IDLE: if (cpu_data_req) begin
                    if (hit0 || hit1) begin
                        cpu_data_addr_ok = 1'b1;
                        cpu_data_data_ok = 1'b1;
                        cpu_data_rdata   = rd_data[hit1];
                        data_we[hit1]    = cpu_data_wr;
                        dirty_set[hit1]  = cpu_data_wr;
                        lru_we           = 1'b1;
                        lru_val          = ~hit1;
                    end else begin
                        victim      = !rd_valid[0] ? 1'b0 : !rd_valid[1] ? 1'b1 : lru_q[acc_index];
                        victim_d    = victim;
                        req_tag_d   = cpu_tag;
                        req_index_d = cpu_index;
                        req_word_d  = cpu_word;
                        cnt_d       = '0;
                        state_d     = (rd_valid[victim] && rd_dirty[victim]) ? WB : RF;
                    end
                end
                WB: begin
                    cache_data_req   = !addr_rcv_q;
                    cache_data_wr    = 1'b1;
                    cache_data_addr  = {rd_tag[victim_q], req_index_q, cnt_q, 2'b00};
                    cache_data_wdata = rd_data[victim_q];
                    if (cache_data_data_ok) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = RF;
                    end
                end
                RF: begin
                    cache_data_req  = !addr_rcv_q;
                    cache_data_addr = {req_tag_q, req_index_q, cnt_q, 2'b00};
                    if (cache_data_data_ok) begin
                        data_we[victim_q] = 1'b1;
                        data_mask         = 4'hF;
                        data_wdata        = cache_data_rdata;
                        cnt_d             = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = DONE;
                    end
                end
                DONE: begin
                    // The held core request finishes here as a hit on the refilled line.
                    line_we[victim_q] = 1'b1;
                    line_dirty        = cpu_data_wr;
                    data_we[victim_q] = cpu_data_wr;
                    cpu_data_addr_ok  = 1'b1;
                    cpu_data_data_ok  = 1'b1;
                    cpu_data_rdata    = rd_data[victim_q];
                    lru_we            = 1'b1;
                    lru_val           = ~victim_q;
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (cache_data_data_ok) addr_rcv_d = 1'b0;
            else if (cache_data_req && cache_data_addr_ok) addr_rcv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_rcv_q  <= 1'b0;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
            victim_q    <= 1'b0;
            for (int i = 0; i < SETS; i++) lru_q[i] <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_rcv_q  <= addr_rcv_d;
            req_tag_q   <= req_tag_d;
            req_index_q <= req_index_d;
            req_word_q  <= req_word_d;
            victim_q    <= victim_d;
            if (lru_we) lru_q[acc_index] <= lru_val;
        end
    end

endmodule

// File: tb/tb_d_cache_wb_2way.sv
// Scoreboard bench: flat-memory/LRU reference model versus the cache, with a stalling bridge model.
module tb_d_cache_wb_2way;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        logic        hit;
        int          issue;
    } cpu_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_data_req, cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
    logic        cache_data_addr_ok, cache_data_data_ok;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] bmem[int unsigned];
    logic [31:0] ref_mem[int unsigned];
    bit          resident[int unsigned];
    int unsigned last_use[int unsigned];
    int unsigned stamp = 0;

    bit          mem_free = 1'b0;
    bit          stall_arm = 1'b0;
    bit          stalling = 1'b0;
    int          stall_left = 0;
    int          stall_seen = 0;
    logic [31:0] stall_addr = '0;
    int          refill_cnt = 0;

    d_cache_wb_2way dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_data_req      (cpu_data_req),
        .cpu_data_wr       (cpu_data_wr),
        .cpu_data_size     (cpu_data_size),
        .cpu_data_addr     (cpu_data_addr),
        .cpu_data_wdata    (cpu_data_wdata),
        .cpu_data_rdata    (cpu_data_rdata),
        .cpu_data_addr_ok  (cpu_data_addr_ok),
        .cpu_data_data_ok  (cpu_data_data_ok),
        .cache_data_req    (cache_data_req),
        .cache_data_wr     (cache_data_wr),
        .cache_data_size   (cache_data_size),
        .cache_data_addr   (cache_data_addr),
        .cache_data_wdata  (cache_data_wdata),
        .cache_data_rdata  (cache_data_rdata),
        .cache_data_addr_ok(cache_data_addr_ok),
        .cache_data_data_ok(cache_data_data_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for the cache", name);
        report();
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    // Reference: flat memory image plus the set of resident lines with use stamps and dirty flags.
    task automatic model_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic hit, output logic [31:0] rdata);
        int unsigned line, word, set_no, victim, n, lo, nb;
        line   = addr & ~32'hF;
        word   = addr & ~32'h3;
        set_no = (line >> 4) % 128;
        hit    = resident.exists(line);
        if (!hit) begin
            n = 0;
            victim = 0;
            foreach (resident[k]) begin
                if (((k >> 4) % 128) == set_no) begin
                    if (n == 0 || last_use[k] < last_use[victim]) victim = k;
                    n++;
                end
            end
            if (n >= 2) begin
                if (resident[victim]) begin
                    for (int i = 0; i < 4; i++)
                        mem_q.push_back('{1'b1, victim + 4*i, ref_rd(victim + 4*i)});
                end
                resident.delete(victim);
                last_use.delete(victim);
            end
            for (int i = 0; i < 4; i++) mem_q.push_back('{1'b0, line + 4*i, 32'h0});
            resident[line] = 1'b0;
        end
        stamp++;
        last_use[line] = stamp;
        if (wr) begin
            nb = 1 << size;
            lo = (size == 2) ? 0 : (addr % 4) & ~(nb - 1);
            rdata = ref_rd(word);
            for (int b = 0; b < 4; b++)
                if (b >= lo && b < lo + nb) rdata[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[word] = rdata;
            resident[line] = 1'b1;
        end
        rdata = ref_rd(word);
    endtask

    task automatic apply_stimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        logic        hit;
        logic [31:0] rd;
        @(negedge clk);
        cpu_data_req   = 1'b1;
        cpu_data_wr    = wr;
        cpu_data_size  = size;
        cpu_data_addr  = addr;
        cpu_data_wdata = wdata;
        model_access(wr, size, addr, wdata, hit, rd);
        cpu_q.push_back('{!wr, rd, hit, cyc});
        for (int t = 0; ; t++) begin
            #1;
            if (cpu_data_addr_ok) break;
            if (t > 400) timeout_fail("addr_ok_wait");
            @(negedge clk);
        end
        @(negedge clk);
        cpu_data_req = 1'b0;
    endtask

    // Core-side monitor: every data_ok pops one expectation.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && cpu_data_data_ok) begin
                check_output("data_ok_with_addr_ok", cpu_data_addr_ok, 1'b1);
                if (cpu_q.size() == 0) begin
                    check_output("unexpected_data_ok", 1'b1, 1'b0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.hit) check_output("hit_latency", cyc - e.issue, 0);
                    else       check_output("miss_latency_nonzero", (cyc - e.issue) != 0, 1'b1);
                    if (e.is_load) check_output("load_rdata", cpu_data_rdata, e.rdata);
                end
            end
        end
    end

    task automatic complete_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cache_data_data_ok = 1'b1;
        if (wr) begin
            bmem[addr] = wdata;
        end else begin
            cache_data_rdata = bmem_rd(addr);
            refill_cnt++;
        end
    endtask

    // Bridge model: random accept stalls and 0..2 cycle data latency; it also checks traffic.
    initial begin
        bit          busy = 1'b0;
        int          delay = 0;
        logic        x_wr;
        logic [31:0] x_addr, x_wdata;
        mem_exp_t    m;
        cache_data_addr_ok = 1'b0;
        cache_data_data_ok = 1'b0;
        cache_data_rdata   = '0;
        forever begin
            @(negedge clk);
            #1;
            cache_data_addr_ok = 1'b0;
            cache_data_data_ok = 1'b0;
            if (rst) begin
                busy     = 1'b0;
                stalling = 1'b0;
            end else if (busy) begin
                if (delay == 0) begin
                    complete_xfer(x_wr, x_addr, x_wdata);
                    busy = 1'b0;
                end else begin
                    delay--;
                end
            end else if (stalling && stall_left > 0) begin
                check_output("stall_req_held", cache_data_req, 1'b1);
                check_output("stall_addr_held", cache_data_addr, stall_addr);
                stall_left--;
                stall_seen++;
            end else if (cache_data_req) begin
                if (stall_arm && cache_data_addr == stall_addr) begin
                    stall_arm  = 1'b0;
                    stalling   = 1'b1;
                    stall_left = 2;
                    stall_seen++;
                end else if (!stalling && $urandom_range(0, 3) == 0) begin
                    stall_left = 0;
                end else begin
                    stalling = 1'b0;
                    x_wr     = cache_data_wr;
                    x_addr   = cache_data_addr;
                    x_wdata  = cache_data_wdata;
                    cache_data_addr_ok = 1'b1;
                    if (!mem_free) begin
                        check_output("mem_size", cache_data_size, 2'b10);
                        if (mem_q.size() == 0) begin
                            check_output("unexpected_mem_req", x_addr, 32'hFFFF_FFFF);
                        end else begin
                            m = mem_q.pop_front();
                            check_output("mem_wr", x_wr, m.wr);
                            check_output("mem_addr", x_addr, m.addr);
                            if (m.wr) check_output("mem_wdata", x_wdata, m.wdata);
                        end
                    end
                    delay = $urandom_range(0, 2);
                    if (delay == 0) complete_xfer(x_wr, x_addr, x_wdata);
                    else begin
                        busy = 1'b1;
                        delay--;
                    end
                end
            end
        end
    end

    task automatic model_reset();
        resident.delete();
        last_use.delete();
        ref_mem = bmem;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst = 1'b1;
        cpu_data_req = 1'b0;
        cpu_data_wr = 1'b0;
        cpu_data_size = 2'b10;
        cpu_data_addr = '0;
        cpu_data_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            bmem[32'h1040 + 4*i] = 32'hA0 + i;
        end
        ref_mem = bmem;

        repeat (2) @(negedge clk);
        cpu_data_req = 1'b1;
        #1;
        check_output("rst_addr_ok", cpu_data_addr_ok, 1'b0);
        check_output("rst_data_ok", cpu_data_data_ok, 1'b0);
        check_output("rst_mem_req", cache_data_req, 1'b0);
        check_output("rst_mem_size", cache_data_size, 2'b00);
        @(negedge clk);
        cpu_data_req = 1'b0;
        rst = 1'b0;

        // Cold miss, hit, byte store merge, fill way1, eviction with a stalled refill word.
        apply_stimulus(1'b0, 2'd2, 32'h1040, 32'h0);
        apply_stimulus(1'b0, 2'd2, 32'h1048, 32'h0);
        apply_stimulus(1'b1, 2'd0, 32'h1049, 32'h0000_EE00);
        apply_stimulus(1'b0, 2'd2, 32'h1048, 32'h0);
        apply_stimulus(1'b0, 2'd2, 32'h1840, 32'h0);
        apply_stimulus(1'b0, 2'd2, 32'h1840, 32'h0);
        stall_addr = 32'h2044;
        stall_arm  = 1'b1;
        apply_stimulus(1'b0, 2'd2, 32'h2040, 32'h0);
        check_output("stall_cycles", stall_seen, 3);
        apply_stimulus(1'b0, 2'd2, 32'h1840, 32'h0);

        // Reset in the middle of a refill abandons it.
        mem_free = 1'b1;
        refill_cnt = 0;
        @(negedge clk);
        cpu_data_req  = 1'b1;
        cpu_data_wr   = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = 32'h3080;
        for (int t = 0; refill_cnt < 2; t++) begin
            if (t > 200) timeout_fail("refill_wait");
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        cpu_data_req = 1'b0;
        #1;
        check_output("midrst_mem_req", cache_data_req, 1'b0);
        check_output("midrst_data_ok", cpu_data_data_ok, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem_free = 1'b0;
        #1;
        check_output("post_rst_mem_req", cache_data_req, 1'b0);
        apply_stimulus(1'b0, 2'd2, 32'h1040, 32'h0);

        // Store miss whose LRU victim is dirty: write-back, refill, then merge.
        apply_stimulus(1'b1, 2'd2, 32'h1044, 32'h1122_3344);
        apply_stimulus(1'b0, 2'd2, 32'h1840, 32'h0);
        apply_stimulus(1'b1, 2'd2, 32'h2048, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 2'd2, 32'h2048, 32'h0);
        apply_stimulus(1'b0, 2'd2, 32'h1840, 32'h0);
        apply_stimulus(1'b0, 2'd2, 32'h3040, 32'h0);
        apply_stimulus(1'b0, 2'd2, 32'h2040, 32'h0);

        // Random traffic over a few sets and tags to force frequent evictions.
        for (int i = 0; i < 400; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = ($urandom_range(4, 7) << 11) | ($urandom_range(0, 3) << 4)
               | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if (sz == 2'd2) a[1:0] = 2'b00;
            if (sz == 2'd1) a[0] = 1'b0;
            apply_stimulus(1'($urandom_range(0, 1)), sz, a, $urandom);
        end

        repeat (5) @(negedge clk);
        check_output("cpu_queue_drained", cpu_q.size(), 0);
        check_output("mem_queue_drained", mem_q.size(), 0);
        report();
    end

endmodule
